// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and instruction-fetch sequencer for the
// multicycle-fetch RISC-V core. Walks BOOT -> FETCH -> EXEC, commits the next
// PC on the edge that leaves EXEC, and counts retired instructions.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to send a commit whose target
// is not word-aligned into a sticky TRAP state (exit only via rst). Without the
// macro, misaligned targets load into pc as-is and trap is tied low.
module pc_sequencer #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PCsrc,
  input  logic [XLEN-1:0]  imm_ext,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             imem_req,
  output logic             instr_valid,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;
`endif

  state_t           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  jalr_sum;
  logic [CNT_W-1:0] instret_q;
  logic             imem_req_q;
  logic             instr_valid_q;

  // Next-PC select; only consumed on the commit edge, so stall-cycle changes are harmless.
  always_comb begin
    pc_d     = pc_q + PC_STEP;
    jalr_sum = rs1_data + imm_ext;
    unique case (PCsrc)
      2'b01:   pc_d = pc_q + imm_ext;
      2'b10:   pc_d = {jalr_sum[XLEN-1:1], 1'b0};
      default: pc_d = pc_q + PC_STEP;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;

  // Sequencer FSM with registered outputs; misaligned commit parks in TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instret_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q       <= S_EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            instr_valid_q <= 1'b0;
            if (pc_d[1:0] != 2'b00) begin
              // pc stays on the faulting instruction and it does not retire.
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
              pc_q       <= pc_d;
              instret_q  <= instret_q + CNT_W'(1);
            end
          end
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign trap = trap_q;
`else
  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instret_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q       <= S_EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            state_q       <= S_FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            pc_q          <= pc_d;
            instret_q     <= instret_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign trap = 1'b0;
`endif

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_STEP;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCsrc;
  logic [31:0] imm_ext;
  logic [31:0] rs1_data;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        instr_valid;
  logic [31:0] instret;
  logic        trap;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .imm_ext     (imm_ext),
    .rs1_data    (rs1_data),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .instr_valid (instr_valid),
    .instret     (instret),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    PCsrc      = 2'b00;
    imm_ext    = '0;
    rs1_data   = '0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_pc",      pc,          32'h0);
    check_eq("rst_req",     imem_req,    32'h0);
    check_eq("rst_valid",   instr_valid, 32'h0);
    check_eq("rst_instret", instret,     32'h0);
    check_eq("rst_trap",    trap,        32'h0);

    // Sequential fetch: pc 0,4,8,12
    rst = 1'b0; imem_ready = 1'b1;
    tick(); // BOOT -> FETCH
    check_eq("boot_req",   imem_req,    32'h1);
    check_eq("boot_valid", instr_valid, 32'h0);
    tick(); // EXEC @0
    check_eq("exec0_valid", instr_valid, 32'h1);
    check_eq("exec0_req",   imem_req,    32'h0);
    check_eq("exec0_p4",    pc_plus4,    32'h4);
    tick(); check_eq("pc4", pc, 32'h4); check_eq("fetch4_req", imem_req, 32'h1);
    tick(); tick(); check_eq("pc8", pc, 32'h8);
    tick(); tick(); check_eq("pc12", pc, 32'hC);
    check_eq("instret3", instret, 32'd3);

    // JAL to 0x100 (imm = 0x100 - 0xC)
    tick(); // EXEC @0xC
    PCsrc = 2'b01; imm_ext = 32'h0000_00F4;
    tick(); check_eq("jal_100", pc, 32'h100);
    tick(); // EXEC @0x100
    check_eq("p4_104", pc_plus4, 32'h104);
    imm_ext = 32'hFFFF_FFF0;
    tick(); check_eq("branch_back", pc, 32'h0F0);

    // JALR with bit 0 cleared
    tick();
    PCsrc = 2'b10; rs1_data = 32'h2001; imm_ext = 32'h4;
    tick(); check_eq("jalr_2004", pc, 32'h2004); check_eq("jalr_trap", trap, 32'h0);

    // JALR to 0x40, then stall 5 cycles with PCsrc toggling
    tick();
    rs1_data = 32'h40; imm_ext = 32'h0;
    tick(); check_eq("jalr_40", pc, 32'h40);
    tick(); // EXEC @0x40
    check_eq("instret_pre_stall", instret, 32'd7);
    stall = 1'b1; rs1_data = 32'h3000; imm_ext = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      PCsrc = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check_eq("stall_pc",      pc,          32'h40);
      check_eq("stall_instret", instret,     32'd7);
      check_eq("stall_valid",   instr_valid, 32'h1);
    end
    stall = 1'b0; PCsrc = 2'b00;
    tick(); check_eq("post_stall_pc", pc, 32'h44); check_eq("instret8", instret, 32'd8);

    // imem_ready low in FETCH, then reset mid-wait
    imem_ready = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wait_req",   imem_req,    32'h1);
      check_eq("wait_valid", instr_valid, 32'h0);
      check_eq("wait_pc",    pc,          32'h44);
    end
    rst = 1'b1; imem_ready = 1'b1;
    tick();
    check_eq("midrst_pc",      pc,       32'h0);
    check_eq("midrst_req",     imem_req, 32'h0);
    check_eq("midrst_instret", instret,  32'h0);
    rst = 1'b0;
    tick(); // BOOT -> FETCH despite imem_ready=1 and stall=1
    check_eq("restart_req",   imem_req,    32'h1);
    check_eq("restart_valid", instr_valid, 32'h0);
    tick(); // FETCH -> EXEC; stall ignored outside EXEC
    check_eq("restart_exec", instr_valid, 32'h1);
    stall = 1'b0;

    // Wrap: jump to 0xFFFF_FFFC then pc+4 wraps to 0
    PCsrc = 2'b10; rs1_data = 32'hFFFF_FFFC; imm_ext = 32'h0;
    tick(); check_eq("pc_top", pc, 32'hFFFF_FFFC);
    tick(); check_eq("p4_wrap", pc_plus4, 32'h0);
    PCsrc = 2'b00;
    tick(); check_eq("pc_wrap", pc, 32'h0);
    tick();
    PCsrc = 2'b01; imm_ext = 32'h10;
    tick(); check_eq("pc_10", pc, 32'h10);
    tick(); // EXEC @0x10
    imm_ext = 32'h6;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check_eq("trap_flag",    trap,        32'h1);
      check_eq("trap_pc",      pc,          32'h10);
      check_eq("trap_req",     imem_req,    32'h0);
      check_eq("trap_valid",   instr_valid, 32'h0);
      check_eq("trap_instret", instret,     32'd3);
      tick();
    end
    rst = 1'b1;
    tick();
    check_eq("trap_clr", trap, 32'h0);
    check_eq("trap_clr_pc", pc, 32'h0);
    rst = 1'b0;
`else
    check_eq("misalign_pc",      pc,       32'h16);
    check_eq("misalign_trap",    trap,     32'h0);
    check_eq("misalign_req",     imem_req, 32'h1);
    check_eq("misalign_instret", instret,  32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
